// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared sizes and FSM state type for the conv output streamer.
package conv_pkg;
    localparam int NUM_POS         = 4;
    localparam int NUM_CH          = 32;
    localparam int PSUM_W          = 32;
    localparam int BIAS_W          = 16;
    localparam int SHIFT           = 8;
    localparam int NUM_ELEM        = NUM_POS * NUM_CH;
    localparam int WORDS_PER_FRAME = NUM_ELEM / 2;
    localparam int CNT_W           = $clog2(WORDS_PER_FRAME);
    localparam int CH_W            = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CAPT   = 2'd1,
        STREAM = 2'd2
    } state_t;
endpackage

// File: rtl/conv_requant.sv
// rtl/conv_requant.sv - bias add, arithmetic shift and 8-bit saturation for one element.
// CONV_OUT_RELU_EN selects unsigned ReLU clamp [0,255]; default is signed clamp [-128,127].
module conv_requant
    import conv_pkg::*;
(
    input  logic signed [PSUM_W-1:0] psum,
    input  logic signed [BIAS_W-1:0] bias,
    output logic        [7:0]        q_byte
);
    localparam int SUM_W = PSUM_W + 2;

    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] q;

`ifdef CONV_OUT_RELU_EN
    localparam logic signed [SUM_W-1:0] Q_MAX = SUM_W'(255);

    always_comb begin
        sum = {{(SUM_W-PSUM_W){psum[PSUM_W-1]}}, psum}
            + {{(SUM_W-BIAS_W){bias[BIAS_W-1]}}, bias};
        q   = sum >>> SHIFT;
        if (q[SUM_W-1]) begin
            q_byte = 8'h00;
        end else if (q > Q_MAX) begin
            q_byte = 8'hFF;
        end else begin
            q_byte = q[7:0];
        end
    end
`else
    localparam logic signed [SUM_W-1:0] Q_MAX = SUM_W'(127);
    localparam logic signed [SUM_W-1:0] Q_MIN = SUM_W'(-128);

    always_comb begin
        sum = {{(SUM_W-PSUM_W){psum[PSUM_W-1]}}, psum}
            + {{(SUM_W-BIAS_W){bias[BIAS_W-1]}}, bias};
        q   = sum >>> SHIFT;
        if (q > Q_MAX) begin
            q_byte = 8'h7F;
        end else if (q < Q_MIN) begin
            q_byte = 8'h80;
        end else begin
            q_byte = q[7:0];
        end
    end
`endif
endmodule

// File: rtl/conv_out_streamer.sv
// rtl/conv_out_streamer.sv - snapshots conv psums and streams requantized byte pairs as 16-bit words.
// Output clamp mode selected by CONV_OUT_RELU_EN (see conv_requant).
module conv_out_streamer
    import conv_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           conv_done,
    input  logic [NUM_ELEM*PSUM_W-1:0]     output_conv,
    input  logic                           done_conv_bias,
    input  logic [NUM_CH*BIAS_W-1:0]       conv_bias,
    output logic [15:0]                    data_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           drop
);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_FRAME - 1);

    state_t                              state_q, state_d;
    logic [NUM_ELEM-1:0][PSUM_W-1:0]     snap_q, snap_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [15:0]                         data_q, data_d;
    logic                                valid_q, valid_d;
    logic                                busy_q, busy_d;
    logic                                fd_q, fd_d;
    logic                                drop_q, drop_d;

    logic [NUM_CH-1:0][BIAS_W-1:0]       bias_arr;
    logic [CNT_W-1:0]                    word_sel;
    logic [CNT_W:0]                      n_lo, n_hi;
    logic [7:0]                          byte_lo, byte_hi;

    assign bias_arr = conv_bias;

    // Word being prepared for the next load: word 0 in CAPT, otherwise the successor of the one on the bus.
    always_comb begin
        word_sel = (state_q == CAPT) ? '0 : cnt_q + CNT_W'(1);
        n_lo     = {word_sel, 1'b0};
        n_hi     = {word_sel, 1'b1};
    end

    conv_requant u_rq_lo (
        .psum   (snap_q[n_lo]),
        .bias   (bias_arr[n_lo[CH_W-1:0]]),
        .q_byte (byte_lo)
    );

    conv_requant u_rq_hi (
        .psum   (snap_q[n_hi]),
        .bias   (bias_arr[n_hi[CH_W-1:0]]),
        .q_byte (byte_hi)
    );

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        fd_d    = 1'b0;
        drop_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (conv_done) begin
                    if (done_conv_bias) begin
                        snap_d  = output_conv;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = CAPT;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end
            end
            CAPT: begin
                drop_d  = conv_done;
                data_d  = {byte_hi, byte_lo};
                valid_d = 1'b1;
                cnt_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                drop_d = conv_done;
                if (valid_q && out_ready) begin
                    if (cnt_q == LAST_WORD) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        fd_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        data_d = {byte_hi, byte_lo};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
            drop_q  <= drop_d;
        end
    end

    // Snapshot is only meaningful after a capture, so it carries no reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign data_out   = data_q;
    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign frame_done = fd_q;
    assign drop       = drop_q;
endmodule

// File: tb/tb_conv_out_streamer.sv
// tb/tb_conv_out_streamer.sv - randomized scoreboard bench for conv_out_streamer (honours CONV_OUT_RELU_EN).
module tb_conv_out_streamer;
    import conv_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        conv_done;
    logic [NUM_ELEM*PSUM_W-1:0]  output_conv;
    logic                        done_conv_bias;
    logic [NUM_CH*BIAS_W-1:0]    conv_bias;
    logic [15:0]                 data_out;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;
    logic                        frame_done;
    logic                        drop;

    conv_out_streamer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .conv_done      (conv_done),
        .output_conv    (output_conv),
        .done_conv_bias (done_conv_bias),
        .conv_bias      (conv_bias),
        .data_out       (data_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .busy           (busy),
        .frame_done     (frame_done),
        .drop           (drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] w;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] acc_log[$];
    int          total_acc = 0;
    int          ps[NUM_ELEM];
    int          bs[NUM_CH];
    int          ready_mode = 0;
    int          rcyc = 0;
    bit          fd_exp = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_data = '0;

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: floor((psum + bias) / 256) then clamp to the byte range of the build.
    function automatic logic [7:0] ref_byte(int p, int b);
        longint s;
        longint q;
        s = longint'(p) + longint'(b);
        if (s >= 0) q = s / 256;
        else        q = -((-s + 255) / 256);
`ifdef CONV_OUT_RELU_EN
        if (q < 0)        return 8'h00;
        else if (q > 255) return 8'hFF;
        else              return 8'(q);
`else
        if (q > 127)       return 8'h7F;
        else if (q < -128) return 8'h80;
        else               return 8'(q);
`endif
    endfunction

    function automatic logic [15:0] ref_word(int k);
        int e0;
        int e1;
        e0 = 2 * k;
        e1 = 2 * k + 1;
        return {ref_byte(ps[e1], bs[e1 % NUM_CH]), ref_byte(ps[e0], bs[e0 % NUM_CH])};
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = (rcyc % 4 == 0) || (rcyc % 4 == 3);
        endcase
        rcyc++;
    end

    // Monitor: pops the scoreboard on every accepted word and tracks stalls and frame_done.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            exp_q.delete();
            fd_exp     = 0;
            prev_stall = 0;
        end else begin
            chk("frame_done", frame_done, fd_exp);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", data_out, prev_data);
            end
            fd_exp = 0;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e.w) begin
                        errors++;
                        $display("FAIL word: got %0h expected %0h at %0t", data_out, e.w, $time);
                    end
                    fd_exp = e.last;
                end
                acc_log.push_back(data_out);
                total_acc++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = data_out;
        end
    end

    task automatic rand_frame();
        shortint sb;
        for (int n = 0; n < NUM_ELEM; n++) begin
            case ($urandom_range(0, 2))
                0:       ps[n] = int'($urandom);
                1:       ps[n] = int'($urandom_range(0, 80000)) - 40000;
                default: ps[n] = int'($urandom_range(0, 1200)) - 600;
            endcase
        end
        for (int c = 0; c < NUM_CH; c++) begin
            sb    = shortint'($urandom);
            bs[c] = int'(sb);
        end
    endtask

    // Starts at the next posedge+1, pushes the frame's words and checks first-word latency.
    task automatic load_and_fire();
        int v;
        @(posedge clk);
        #1;
        for (int n = 0; n < NUM_ELEM; n++) begin
            v = ps[n];
            output_conv[n*PSUM_W +: PSUM_W] = v;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            v = bs[c];
            conv_bias[c*BIAS_W +: BIAS_W] = v[15:0];
        end
        for (int k = 0; k < WORDS_PER_FRAME; k++) begin
            exp_q.push_back('{w: ref_word(k), last: (k == WORDS_PER_FRAME - 1)});
        end
        done_conv_bias = 1'b1;
        conv_done      = 1'b1;
        @(posedge clk);
        #1;
        conv_done = 1'b0;
        @(negedge clk);
        chk("capt_valid_low", out_valid, 0);
        chk("capt_busy", busy, 1);
        @(negedge clk);
        chk("first_valid", out_valid, 1);
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", (n < budget), 1);
    endtask

    task automatic wait_acc(int target, int budget);
        int n;
        n = 0;
        while (total_acc < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("acc_timeout", (n < budget), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        rst_n          = 1'b1;
        conv_done      = 1'b0;
        done_conv_bias = 1'b0;
        output_conv    = '0;
        conv_bias      = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data_out, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_drop", drop, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        // Basic frame with fixed leading elements
        rand_frame();
        ps[0] = 1000;    bs[0] = 24;
        ps[1] = -500;    bs[1] = 0;
        ps[2] = 100000;  bs[2] = 0;
        ps[3] = -100000; bs[3] = 0;
        base = total_acc;
        load_and_fire();
        wait_idle(500);
        chk("basic_count", total_acc - base, 64);
`ifdef CONV_OUT_RELU_EN
        chk("basic_word0", acc_log[base], 16'h0004);
        chk("basic_word1", acc_log[base+1], 16'h00FF);
`else
        chk("basic_word0", acc_log[base], 16'hFE04);
        chk("basic_word1", acc_log[base+1], 16'h807F);
`endif

        // Backpressure pattern from word 5
        rand_frame();
        base = total_acc;
        load_and_fire();
        wait_acc(base + 5, 200);
        ready_mode = 2;
        wait_idle(1000);
        ready_mode = 0;
        chk("bp_count", total_acc - base, 64);

        // conv_done while streaming is dropped; random ready throughout
        rand_frame();
        base = total_acc;
        ready_mode = 1;
        load_and_fire();
        wait_acc(base + 10, 500);
        @(posedge clk);
        #1;
        output_conv = {NUM_ELEM{32'hDEADBEEF}};
        conv_done   = 1'b1;
        @(posedge clk);
        #1;
        conv_done = 1'b0;
        @(negedge clk);
        chk("busy_drop", drop, 1);
        @(negedge clk);
        chk("busy_drop_pulse", drop, 0);
        wait_idle(2000);
        ready_mode = 0;
        chk("drop_count", total_acc - base, 64);

        // conv_done in IDLE without bias loaded
        @(posedge clk);
        #1;
        done_conv_bias = 1'b0;
        conv_done      = 1'b1;
        @(posedge clk);
        #1;
        conv_done = 1'b0;
        @(negedge clk);
        chk("nobias_drop", drop, 1);
        chk("nobias_busy", busy, 0);
        @(negedge clk);
        chk("nobias_drop_pulse", drop, 0);
        chk("nobias_valid", out_valid, 0);
        chk("nobias_busy2", busy, 0);

        // Reset mid-stream then a fresh frame
        rand_frame();
        base = total_acc;
        load_and_fire();
        wait_acc(base + 30, 200);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_fd", frame_done, 0);
        rand_frame();
        base = total_acc;
        load_and_fire();
        wait_idle(500);
        chk("postrst_count", total_acc - base, 64);
        chk("postrst_word0", acc_log[base], ref_word(0));

        // Back-to-back frames: second conv_done the cycle after frame_done
        rand_frame();
        base = total_acc;
        load_and_fire();
        n = 0;
        while (!frame_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_fd_seen", (n < 500), 1);
        rand_frame();
        load_and_fire();
        wait_idle(500);
        chk("b2b_count", total_acc - base, 128);
        chk("b2b_last_word", acc_log[total_acc-1], ref_word(WORDS_PER_FRAME - 1));

        repeat (3) @(negedge clk);
        chk("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_out_streamer.md
Name: conv_out_streamer

Overview:
Transmit end of the conv datapath: the mirror of the 16-bit data_in loader.
- On a conv_done strobe from the psum buffer, snapshots the parallel output_conv vector (4 positions x 32 channels x 32 bit).
- Adds the per-channel conv bias, requantizes each result to 8 bits and packs two results per 16-bit word, low byte first (same packing as image input).
- Streams 64 words out under a valid/ready handshake to the next layer or the host readback path.

Parameters:
NUM_POS, 4, output positions per conv_done
NUM_CH, 32, channels per position
PSUM_W, 32, psum width (signed)
BIAS_W, 16, bias width (signed)
SHIFT, 8, arithmetic right shift applied after bias add

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-high (1 = reset)
conv_done  in  1  single-cycle strobe: output_conv valid this cycle
output_conv  in  NUM_POS*NUM_CH*PSUM_W  element n = p*NUM_CH+c at bits [(n+1)*32-1:n*32]
done_conv_bias  in  1  level: conv_bias fully loaded
conv_bias  in  NUM_CH*BIAS_W  bias c at bits [(c+1)*16-1:c*16]
data_out  out  16  packed word: [7:0] element 2k, [15:8] element 2k+1
out_valid  out  1  data_out valid
out_ready  in  1  sink accepts when out_valid & out_ready
busy  out  1  high from capture until last word accepted
frame_done  out  1  one-cycle pulse with acceptance of word 63
drop  out  1  one-cycle pulse: conv_done ignored

Behaviour:
- Reset (rst_n=1 at posedge): state IDLE; data_out=0; out_valid, busy, frame_done, drop = 0; word counter = 0. Reset overrides all other activity, including mid-stream: the current frame is discarded with no frame_done.
- States: IDLE, CAPT, STREAM.
- IDLE, conv_done=1 and done_conv_bias=1: latch output_conv into the snapshot register; go to CAPT; busy=1.
- IDLE, conv_done=1 and done_conv_bias=0: drop pulse; stay in IDLE.
- CAPT: register word 0 into data_out; out_valid=1; go to STREAM.
  - First word is valid 2 cycles after conv_done is sampled.
- STREAM: on out_valid & out_ready:
  - If word counter = 63: out_valid=0, busy=0, frame_done=1, state IDLE.
  - Otherwise: counter+1 and the next word is loaded the same edge. No bubble, so full rate is 1 word/cycle.
- Backpressure: while out_valid & !out_ready, data_out and counter are held stable.
- conv_done while busy (CAPT/STREAM): drop pulse. Snapshot is untouched. No queuing.
- conv_done on the same edge that word 63 is accepted: dropped. IDLE is required for capture.
- Per element n, channel c = n mod NUM_CH:
  - s = sext34(psum[n]) + sext34(bias[c]); no overflow is possible.
  - q = s >>> SHIFT (arithmetic).
  - Saturate per the Optional Feature.
- Ordering: word k carries elements 2k and 2k+1, so the stream runs position-major, channel-minor.
- conv_bias is sampled live during STREAM. Upstream holds it constant once done_conv_bias=1.

Optional Feature:
Macro: CONV_OUT_RELU_EN
- Defined: q<0 gives 0x00; q>255 gives 0xFF; otherwise q[7:0] (unsigned ReLU output).
- Undefined: signed saturation to [-128,127], emitted as two's-complement byte.

Decomposition:
- Package conv_pkg:
  - NUM_POS, NUM_CH, PSUM_W, BIAS_W, SHIFT.
  - WORDS_PER_FRAME = NUM_POS*NUM_CH/2 = 64.
  - State enum {IDLE, CAPT, STREAM}.
- Sub-module conv_requant: combinational psum+bias, shift and saturate for one element. Instantiated twice, for the low and high byte.
- The top holds the FSM, snapshot register, counter and output register.

Test Plan:
- Basic: psum[0]=1000, bias[0]=24, psum[1]=-500, bias[1]=0, out_ready=1 -> word0 = 16'h0004 with RELU_EN (16'hFE04 without); 64 words; frame_done with word 63; first out_valid 2 cycles after conv_done.
- Saturation: psum[2]=100000, bias[2]=0 -> byte 0xFF (RELU) / 0x7F (no RELU); psum[3]=-100000 -> 0x00 / 0x80.
- Backpressure: out_ready toggles 1,0,0,1 from word 5 -> data_out held stable while stalled; no word lost or duplicated; 64 total.
- Drop: conv_done at word 10 -> drop=1 for one cycle, stream unaffected; conv_done with done_conv_bias=0 in IDLE -> drop, busy stays 0.
- Reset mid-stream: rst_n=1 at word 30 -> next cycle out_valid=0, busy=0, no frame_done; fresh conv_done then streams word 0.
- Back-to-back: conv_done one cycle after frame_done -> captured; second frame bit-exact vs model.
